// File: rtl/sobel_pkg.sv
// Shared constants for the streaming Sobel edge detector.
package sobel_pkg;

  localparam int unsigned SOB_DW   = 8;
  // Gradient/magnitude width: |Gx|+|Gy| needs 3 bits of growth over the pixel width.
  localparam int unsigned MAG_W    = SOB_DW + 3;
  localparam int unsigned SOB_LAT  = 3;
  localparam logic        MODE_BIN = 1'b0;
  localparam logic        MODE_MAG = 1'b1;

endpackage

// File: rtl/sobel_line_buf.sv
// One image line of pixel storage: single-clock RAM with registered (synchronous) read.
module sobel_line_buf
  import sobel_pkg::*;
#(
  parameter int unsigned DEPTH = 100,
  parameter int unsigned DW    = SOB_DW,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge detector: raster pixels in on pi_flag, one result per interior
// pixel out exactly three clocks after the pixel that completes its window.
module sobel_stream
  import sobel_pkg::*;
#(
  parameter int unsigned IMG_W = 100,
  parameter int unsigned IMG_H = 100,
  parameter int unsigned DW    = SOB_DW
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          pi_flag,
  input  logic [DW-1:0] pi_data,
  input  logic [DW-1:0] threshold,
  input  logic          mode,
  output logic          po_flag,
  output logic [DW-1:0] po_data,
  output logic          po_end
);

  localparam int unsigned MW = DW + (MAG_W - SOB_DW);
  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);

  logic          acc, last_col, last_row;
  logic [CW-1:0] col_q, col_d, raddr;
  logic [RW-1:0] row_q, row_d;
  logic [DW-1:0] mid_rd, top_rd;

  assign acc      = pi_flag & ~sys_rst;
  assign last_col = (col_q == CW'(IMG_W - 1));
  assign last_row = (row_q == RW'(IMG_H - 1));

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (acc) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // Read ahead at the next column so the RAM output is ready when the next pixel arrives.
  assign raddr = sys_rst ? '0 : col_d;

  sobel_line_buf #(.DEPTH(IMG_W), .DW(DW)) u_lb_mid (
    .clk   (sys_clk),
    .we    (acc),
    .waddr (col_q),
    .wdata (pi_data),
    .raddr (raddr),
    .rdata (mid_rd)
  );

  sobel_line_buf #(.DEPTH(IMG_W), .DW(DW)) u_lb_top (
    .clk   (sys_clk),
    .we    (acc),
    .waddr (col_q),
    .wdata (mid_rd),
    .raddr (raddr),
    .rdata (top_rd)
  );

  // Window indexed [row][col], row 0 = oldest line, col 2 = newest column.
  logic [DW-1:0]        win_q [3][3];
  logic [DW-1:0]        win_d [3][3];
  logic signed [MW-1:0] p     [3][3];
  logic signed [MW-1:0] gx_d, gy_d, gx_q, gy_q;

  always_comb begin
    win_d = win_q;
    if (acc) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = top_rd;
      win_d[1][2] = mid_rd;
      win_d[2][2] = pi_data;
    end
  end

  always_ff @(posedge sys_clk) begin
    win_q <= win_d;
  end

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) p[r][c] = $signed(MW'(win_d[r][c]));
    end
    gx_d = (p[0][2] + p[1][2] + p[1][2] + p[2][2]) - (p[0][0] + p[1][0] + p[1][0] + p[2][0]);
    gy_d = (p[2][0] + p[2][1] + p[2][1] + p[2][2]) - (p[0][0] + p[0][1] + p[0][1] + p[0][2]);
  end

  logic          v1_d, e1_d, v1_q, e1_q, v2_q, e2_q, mode1_q, mode2_q;
  logic [DW-1:0] thr1_q, thr2_q, res_d;
  logic [MW-1:0] abs_gx, abs_gy, mag_d, mag_q;

  assign v1_d = acc && (row_q >= RW'(2)) && (col_q >= CW'(2));
  assign e1_d = v1_d && last_row && last_col;

  always_comb begin
    abs_gx = gx_q[MW-1] ? MW'(-gx_q) : MW'(gx_q);
    abs_gy = gy_q[MW-1] ? MW'(-gy_q) : MW'(gy_q);
    mag_d  = abs_gx + abs_gy;
  end

  always_comb begin
    res_d = '0;
    if (mode2_q == MODE_MAG) begin
      res_d = (mag_q > MW'({DW{1'b1}})) ? '1 : mag_q[DW-1:0];
    end else if (mag_q > MW'(thr2_q)) begin
      res_d = '1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      v1_q    <= 1'b0;
      e1_q    <= 1'b0;
      v2_q    <= 1'b0;
      e2_q    <= 1'b0;
      gx_q    <= '0;
      gy_q    <= '0;
      mag_q   <= '0;
      mode1_q <= MODE_BIN;
      mode2_q <= MODE_BIN;
      thr1_q  <= '0;
      thr2_q  <= '0;
      po_flag <= 1'b0;
      po_end  <= 1'b0;
      po_data <= '0;
    end else begin
      v1_q    <= v1_d;
      e1_q    <= e1_d;
      gx_q    <= gx_d;
      gy_q    <= gy_d;
      mode1_q <= mode;
      thr1_q  <= threshold;
      v2_q    <= v1_q;
      e2_q    <= e1_q;
      mag_q   <= mag_d;
      mode2_q <= mode1_q;
      thr2_q  <= thr1_q;
      po_flag <= v2_q;
      po_end  <= e2_q;
      if (v2_q) po_data <= res_d;
    end
  end

endmodule

// File: tb/tb_sobel_stream.sv
// Randomised self-checking bench for sobel_stream against a direct Sobel reference model.
module tb_sobel_stream;
  import sobel_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst_a, pf_a, mode_a, of_a, oe_a;
  logic [7:0] pd_a, thr_a, od_a;
  logic       rst_b, pf_b, mode_b, of_b, oe_b;
  logic [7:0] pd_b, thr_b, od_b;

  sobel_stream #(.IMG_W(8), .IMG_H(8), .DW(8)) dut_a (
    .sys_clk (clk), .sys_rst (rst_a), .pi_flag (pf_a), .pi_data (pd_a),
    .threshold (thr_a), .mode (mode_a), .po_flag (of_a), .po_data (od_a), .po_end (oe_a)
  );

  sobel_stream #(.IMG_W(5), .IMG_H(4), .DW(8)) dut_b (
    .sys_clk (clk), .sys_rst (rst_b), .pi_flag (pf_b), .pi_data (pd_b),
    .threshold (thr_b), .mode (mode_b), .po_flag (of_b), .po_data (od_b), .po_end (oe_b)
  );

  int errors = 0;
  int checks = 0;
  int mon_sel = 0;
  int w_cur = 8;
  int h_cur = 8;
  logic [7:0] img [8][8];

  logic [7:0] exp_d[$], got_d[$], saved[$];
  logic       exp_e[$], got_e[$];
  int         exp_c[$], got_c[$];

  always @(negedge clk) begin
    if (mon_sel == 0 && of_a === 1'b1) begin
      got_d.push_back(od_a); got_e.push_back(oe_a); got_c.push_back(cyc);
    end
    if (mon_sel == 1 && of_b === 1'b1) begin
      got_d.push_back(od_b); got_e.push_back(oe_b); got_c.push_back(cyc);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int px(int r, int c);
    return int'(img[r][c]);
  endfunction

  // Golden results for the whole image currently in img, in raster order of centres.
  function automatic void model_frame(int w, int h, logic md, logic [7:0] th);
    for (int r = 1; r <= h - 2; r++) begin
      for (int c = 1; c <= w - 2; c++) begin
        int gx, gy, mag;
        gx = (px(r-1, c+1) + 2 * px(r, c+1) + px(r+1, c+1))
           - (px(r-1, c-1) + 2 * px(r, c-1) + px(r+1, c-1));
        gy = (px(r+1, c-1) + 2 * px(r+1, c) + px(r+1, c+1))
           - (px(r-1, c-1) + 2 * px(r-1, c) + px(r-1, c+1));
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        if (md) exp_d.push_back(8'(mag > 255 ? 255 : mag));
        else    exp_d.push_back(mag > int'(th) ? 8'hFF : 8'h00);
        exp_e.push_back(r == h - 2 && c == w - 2);
      end
    end
  endfunction

  task automatic fill(int pat);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        case (pat)
          0:       img[r][c] = 8'h40;
          1:       img[r][c] = (c < 4) ? 8'h00 : 8'hFF;
          2:       img[r][c] = 8'(10 * c);
          default: img[r][c] = 8'($urandom_range(0, 255));
        endcase
  endtask

  task automatic drive(int sel, logic f, logic [7:0] d, logic [7:0] th, logic md);
    if (sel == 0) begin pf_a = f; pd_a = d; thr_a = th; mode_a = md; end
    else          begin pf_b = f; pd_b = d; thr_b = th; mode_b = md; end
  endtask

  task automatic send_pixels(int sel, int n, int period, logic md, logic [7:0] th);
    for (int k = 0; k < n; k++) begin
      int r = k / w_cur;
      int c = k % w_cur;
      @(negedge clk);
      drive(sel, 1'b1, img[r][c], th, md);
      if (r >= 2 && c >= 2) exp_c.push_back(cyc + int'(SOB_LAT));
      if (period > 1) begin
        @(negedge clk);
        drive(sel, 1'b0, img[r][c], th, md);
        repeat (period - 2) @(negedge clk);
      end
    end
  endtask

  task automatic finish_stream(int sel);
    @(negedge clk);
    drive(sel, 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (SOB_LAT + 3) @(negedge clk);
  endtask

  task automatic run_frame(int sel, int period, logic md, logic [7:0] th);
    model_frame(w_cur, h_cur, md, th);
    send_pixels(sel, w_cur * h_cur, period, md, th);
    finish_stream(sel);
  endtask

  task automatic clear_q();
    exp_d.delete(); exp_e.delete(); exp_c.delete();
    got_d.delete(); got_e.delete(); got_c.delete();
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1;
    drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
    drive(1, 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    drive(0, 1'b1, 8'hAA, 8'h00, 1'b1);
    @(negedge clk);
    drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
    checks += 2;
    if ({of_a, oe_a, od_a} !== 10'd0) begin
      errors++; $display("FAIL reset_a: flag=%b end=%b data=%h, expected 0 0 00", of_a, oe_a, od_a);
    end
    if ({of_b, oe_b, od_b} !== 10'd0) begin
      errors++; $display("FAIL reset_b: flag=%b end=%b data=%h, expected 0 0 00", of_b, oe_b, od_b);
    end
    rst_a = 1'b0; rst_b = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (got_d.size() != 0) begin
      errors++; $display("FAIL reset_idle: %0d results, expected 0", got_d.size());
    end
    clear_q();
  endtask

  task automatic test_flat();
    int ends = 0;
    fill(0);
    run_frame(0, 1, MODE_MAG, 8'd0);
    checks++;
    if (got_d.size() != 36) begin
      errors++; $display("FAIL flat_count: %0d results, expected 36", got_d.size());
    end
    for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
      checks++;
      if (got_d[i] !== 8'h00 || got_d[i] !== exp_d[i] || got_e[i] !== exp_e[i] || got_c[i] != exp_c[i]) begin
        errors++;
        $display("FAIL flat[%0d]: data=%h end=%b cyc=%0d, expected data=%h end=%b cyc=%0d",
                 i, got_d[i], got_e[i], got_c[i], exp_d[i], exp_e[i], exp_c[i]);
      end
      if (got_e[i] === 1'b1) ends++;
    end
    checks++;
    if (ends != 1 || got_e.size() != 36 || got_e[35] !== 1'b1) begin
      errors++; $display("FAIL flat_end: %0d po_end pulses, expected 1 on result 36", ends);
    end
    clear_q();
  endtask

  // Frames: step binary thr 100, step magnitude, ramp magnitude, ramp thr 80, ramp thr 79.
  task automatic test_patterns();
    int         pats [5] = '{1, 1, 2, 2, 2};
    logic       mds  [5] = '{MODE_BIN, MODE_MAG, MODE_MAG, MODE_BIN, MODE_BIN};
    logic [7:0] ths  [5] = '{8'd100, 8'd0, 8'd0, 8'd80, 8'd79};
    for (int t = 0; t < 5; t++) begin
      fill(pats[t]);
      run_frame(0, 1, mds[t], ths[t]);
      checks++;
      if (got_d.size() != exp_d.size()) begin
        errors++; $display("FAIL pattern%0d_count: %0d results, expected %0d", t, got_d.size(), exp_d.size());
      end
      for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
        checks++;
        if (got_d[i] !== exp_d[i] || got_e[i] !== exp_e[i] || got_c[i] != exp_c[i]) begin
          errors++;
          $display("FAIL pattern%0d[%0d]: data=%h end=%b cyc=%0d, expected data=%h end=%b cyc=%0d",
                   t, i, got_d[i], got_e[i], got_c[i], exp_d[i], exp_e[i], exp_c[i]);
        end
      end
      clear_q();
    end
  endtask

  task automatic test_sparse();
    logic       md = 1'($urandom);
    logic [7:0] th = 8'($urandom_range(0, 255));
    fill(3);
    for (int pass = 0; pass < 2; pass++) begin
      run_frame(0, pass == 0 ? 520 : 1, md, th);
      checks++;
      if (got_d.size() != 36) begin
        errors++; $display("FAIL sparse%0d_count: %0d results, expected 36", pass, got_d.size());
      end
      for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
        checks++;
        if (got_d[i] !== exp_d[i] || got_e[i] !== exp_e[i] || got_c[i] != exp_c[i]) begin
          errors++;
          $display("FAIL sparse%0d[%0d]: data=%h end=%b cyc=%0d, expected data=%h end=%b cyc=%0d",
                   pass, i, got_d[i], got_e[i], got_c[i], exp_d[i], exp_e[i], exp_c[i]);
        end
      end
      if (pass == 1) begin
        checks++;
        if (got_d != saved) begin
          errors++; $display("FAIL sparse_vs_b2b: sequences differ (%0d vs %0d results)", saved.size(), got_d.size());
        end
      end
      saved = got_d;
      clear_q();
    end
  endtask

  task automatic test_reset_mid();
    logic       md = 1'($urandom);
    logic [7:0] th = 8'($urandom_range(0, 255));
    fill(3);
    send_pixels(0, 20, 1, md, th);
    @(negedge clk);
    rst_a = 1'b1;
    drive(0, 1'b1, 8'h5A, th, md);
    @(negedge clk);
    drive(0, 1'b0, 8'h00, th, md);
    @(negedge clk);
    rst_a = 1'b0;
    repeat (SOB_LAT + 3) @(negedge clk);
    checks++;
    if (got_d.size() != 0) begin
      errors++; $display("FAIL abort_outputs: %0d results, expected 0", got_d.size());
    end
    clear_q();
    fill(3);
    run_frame(0, 1, md, th);
    checks++;
    if (got_d.size() != 36) begin
      errors++; $display("FAIL after_reset_count: %0d results, expected 36", got_d.size());
    end
    for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_e[i] !== exp_e[i] || got_c[i] != exp_c[i]) begin
        errors++;
        $display("FAIL after_reset[%0d]: data=%h end=%b cyc=%0d, expected data=%h end=%b cyc=%0d",
                 i, got_d[i], got_e[i], got_c[i], exp_d[i], exp_e[i], exp_c[i]);
      end
    end
    clear_q();
  endtask

  task automatic test_back_to_back();
    logic       md = MODE_MAG;
    int         ends = 0;
    mon_sel = 1; w_cur = 5; h_cur = 4;
    for (int f = 0; f < 2; f++) begin
      fill(3);
      model_frame(w_cur, h_cur, md, 8'd0);
      send_pixels(1, w_cur * h_cur, 1, md, 8'd0);
    end
    finish_stream(1);
    checks++;
    if (got_d.size() != 12) begin
      errors++; $display("FAIL b2b_count: %0d results, expected 12", got_d.size());
    end
    for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_e[i] !== exp_e[i] || got_c[i] != exp_c[i]) begin
        errors++;
        $display("FAIL b2b[%0d]: data=%h end=%b cyc=%0d, expected data=%h end=%b cyc=%0d",
                 i, got_d[i], got_e[i], got_c[i], exp_d[i], exp_e[i], exp_c[i]);
      end
      if (got_e[i] === 1'b1) ends++;
    end
    checks++;
    if (ends != 2) begin
      errors++; $display("FAIL b2b_end: %0d po_end pulses, expected 2", ends);
    end
    clear_q();
    mon_sel = 0; w_cur = 8; h_cur = 8;
  endtask

  initial begin
    test_reset();
    test_flat();
    test_patterns();
    test_sparse();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
